// File: rtl/mul_arb_pkg.sv
// rtl/mul_arb_pkg.sv - shared types and constants for the multiplier-sharing arbiter
package mul_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } mul_arb_state_t;

    localparam logic [7:0] ERR_PRODUCT = 8'hFF;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after ptr, with wrap
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    always_comb begin
        int idx;
        logic [ID_W-1:0] idx_w;
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = ID_W'(idx);
            if (!any && req[idx_w]) begin
                any          = 1'b1;
                grant[idx_w] = 1'b1;
                id           = idx_w;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one 4x4 multiplier between NUM_REQ requesters
// Optional WAIT watchdog with rsp_err port: MUL_ARB_TIMEOUT_EN
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
`ifdef MUL_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 32,
`endif
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_y,
    output logic                 mul_ena,
    output logic [3:0]           mul_a,
    output logic [3:0]           mul_b,
    input  logic [7:0]           mul_y,
    input  logic                 mul_done,
`ifdef MUL_ARB_TIMEOUT_EN
    output logic                 rsp_err,
`endif
    output logic                 busy
);

    mul_arb_state_t state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [3:0]      mul_a_q, mul_a_d;
    logic [3:0]      mul_b_q, mul_b_d;
    logic [7:0]      rsp_y_q, rsp_y_d;
    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_id;
    logic               pick_any;
    logic [3:0]         sel_a, sel_b;
    logic               wait_expired;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .id    (pick_id),
        .any   (pick_any)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_a = req_a[4*i +: 4];
                sel_b = req_b[4*i +: 4];
            end
        end
    end

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_err_q, rsp_err_d;

    assign wait_expired = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err      = rsp_err_q;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        rsp_err_d = rsp_err_q;
        if (state_q == ARB_ISSUE) begin
            tmo_cnt_d = '0;
        end else if (state_q == ARB_WAIT) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            if (mul_done) begin
                rsp_err_d = 1'b0;
            end else if (wait_expired) begin
                rsp_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
`else
    assign wait_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (pick_any) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT:  if (mul_done || wait_expired) state_d = ARB_RESP;
            ARB_RESP:  if (rsp_ready) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Operands stay registered through WAIT since the multiplier resamples them every cycle.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        rsp_y_d  = rsp_y_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    id_d    = pick_id;
                    mul_a_d = sel_a;
                    mul_b_d = sel_b;
                end
            end
            ARB_WAIT: begin
                if (mul_done) begin
                    rsp_y_d = mul_y;
                end else if (wait_expired) begin
                    rsp_y_d = ERR_PRODUCT;
                end
            end
            ARB_RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            id_q     <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            rsp_y_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            rsp_y_q  <= rsp_y_d;
        end
    end

    // req_ready is gated by rst so that it also reads 0 while reset is held.
    always_comb begin
        req_ready = '0;
        mul_ena   = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ARB_IDLE:  req_ready = pick_grant & {NUM_REQ{rst}};
            ARB_ISSUE: begin
                mul_ena = 1'b1;
                busy    = 1'b1;
            end
            ARB_WAIT:  busy = 1'b1;
            ARB_RESP: begin
                rsp_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;
    assign rsp_id = id_q;
    assign rsp_y  = rsp_y_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;

    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int TMO = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready;
    logic [4*N-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [7:0]     rsp_y;
    logic           mul_ena, mul_done, busy;
    logic [3:0]     mul_a, mul_b;
    logic [7:0]     mul_y;
`ifdef MUL_ARB_TIMEOUT_EN
    logic           rsp_err;
`endif

    always #5 clk = ~clk;

    mul_share_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .mul_ena   (mul_ena),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_y     (mul_y),
        .mul_done  (mul_done),
`ifdef MUL_ARB_TIMEOUT_EN
        .rsp_err   (rsp_err),
`endif
        .busy      (busy)
    );

    // Multiplier model: done one cycle, mul_lat cycles after ena; mul_lat == 0 means never.
    int   mul_lat = 6;
    int   mcnt = 0;
    logic ena_s, rst_s;
    initial mul_done = 1'b0;
    assign mul_y = mul_done ? ({4'b0, mul_a} * {4'b0, mul_b}) : 8'h5A;

    always begin
        @(negedge clk);
        ena_s = mul_ena;
        rst_s = rst;
        @(posedge clk);
        #1;
        if (!rst_s) mcnt = 0;
        else if (ena_s) mcnt = mul_lat;
        else if (mcnt > 0) mcnt = mcnt - 1;
        mul_done = (mcnt == 1);
    end

    typedef struct {
        int id; int a; int b; int y; int err; int ena_cyc; int due;
    } txn_t;

    typedef struct {
        int id; int a; int b; int y;
    } vec_t;

    txn_t         exp_q[$];
    txn_t         rsp_log[$];
    int           grant_log[$];
    logic [N-1:0] pend;
    logic [N-1:0] granted_now;
    int           op_a[N], op_b[N];
    bit           sticky[N];
    bit           rand_mode = 1'b0;
    int           model_ptr = 0;
    int           n_chk = 0, n_fail = 0, n_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_a[4*i +: 4] = 4'(op_a[i]);
            req_b[4*i +: 4] = 4'(op_b[i]);
        end
    endtask

    function automatic int predict();
        for (int k = 0; k < N; k++) begin
            if (pend[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic observe();
        int   p;
        txn_t t;
        n_cyc++;
        granted_now = '0;
        if (exp_q.size() == 0) begin
            p = predict();
            chk("grant", 32'(req_ready), (p < 0) ? 32'd0 : (32'd1 << p));
            chk("idle_busy", busy, 0);
            chk("idle_mul_ena", mul_ena, 0);
            chk("idle_rsp_valid", rsp_valid, 0);
            if (p >= 0) begin
                t.id      = p;
                t.a       = op_a[p];
                t.b       = op_b[p];
                t.y       = (mul_lat == 0) ? 255 : op_a[p] * op_b[p];
                t.err     = (mul_lat == 0) ? 1 : 0;
                t.ena_cyc = n_cyc + 1;
                t.due     = t.ena_cyc + ((mul_lat == 0) ? TMO : mul_lat) + 1;
                exp_q.push_back(t);
                grant_log.push_back(p);
                granted_now[p] = 1'b1;
            end
        end else begin
            t = exp_q[0];
            chk("busy_no_grant", 32'(req_ready), 0);
            chk("busy", busy, 1);
            chk("mul_ena", mul_ena, 32'(n_cyc == t.ena_cyc));
            chk("mul_a_hold", mul_a, t.a);
            chk("mul_b_hold", mul_b, t.b);
            chk("rsp_valid", rsp_valid, 32'(n_cyc >= t.due));
            if (rsp_valid) begin
                chk("rsp_id", rsp_id, t.id);
                chk("rsp_y", rsp_y, t.y);
`ifdef MUL_ARB_TIMEOUT_EN
                chk("rsp_err", rsp_err, t.err);
`endif
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    t.id = int'(rsp_id);
                    t.y  = int'(rsp_y);
                    rsp_log.push_back(t);
                    model_ptr = (t.id + 1) % N;
                end
            end
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            if (granted_now[i]) begin
                if (sticky[i]) begin
                    op_a[i] = $urandom_range(0, 15);
                    op_b[i] = $urandom_range(0, 15);
                end else begin
                    pend[i] = 1'b0;
                end
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    op_a[i] = $urandom_range(0, 15);
                    op_b[i] = $urandom_range(0, 15);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        drive();
    endtask

    task automatic cycle();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic run_until_quiet(input int budget);
        int c = 0;
        while ((pend != '0 || exp_q.size() > 0) && c < budget) begin
            cycle();
            c++;
        end
        chk("quiet_within_budget", 32'(c < budget), 1);
    endtask

    task automatic request(input int id, input int a, input int b);
        pend[id] = 1'b1;
        op_a[id] = a;
        op_b[id] = b;
        drive();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_y"}, rsp_y, 0);
        chk({tag, "_mul_ena"}, mul_ena, 0);
        chk({tag, "_mul_a"}, mul_a, 0);
        chk({tag, "_mul_b"}, mul_b, 0);
        chk({tag, "_busy"}, busy, 0);
`ifdef MUL_ARB_TIMEOUT_EN
        chk({tag, "_rsp_err"}, rsp_err, 0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   c;
        int   n_grants;
        vecs[0] = '{id: 1, a: 7,  b: 9,  y: 63};
        vecs[1] = '{id: 3, a: 15, b: 15, y: 225};
        vecs[2] = '{id: 2, a: 0,  b: 13, y: 0};
        vecs[3] = '{id: 0, a: 15, b: 1,  y: 15};
        vecs[4] = '{id: 1, a: 8,  b: 8,  y: 64};
        vecs[5] = '{id: 2, a: 12, b: 11, y: 132};

        // Reset with all four requesters already presenting A=i+1, B=3.
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            sticky[i] = 1'b0;
            op_a[i] = i + 1;
            op_b[i] = 3;
        end
        pend = '1;
        drive();
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_until_quiet(200);
        chk("simul_count", rsp_log.size(), 4);
        if (rsp_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("simul_order_id", rsp_log[i].id, i);
                chk("simul_order_y", rsp_log[i].y, 3 * (i + 1));
            end
        end

        // Table-driven single requests.
        for (int v = 0; v < 6; v++) begin
            rsp_log.delete();
            n_grants = grant_log.size();
            request(vecs[v].id, vecs[v].a, vecs[v].b);
            run_until_quiet(100);
            chk("vec_grant_pulses", grant_log.size() - n_grants, 1);
            chk("vec_rsp_count", rsp_log.size(), 1);
            if (rsp_log.size() == 1) begin
                chk("vec_rsp_id", rsp_log[0].id, vecs[v].id);
                chk("vec_rsp_y", rsp_log[0].y, vecs[v].y);
            end
        end

        // Requesters 0 and 2 keep requesting: grants must alternate.
        grant_log.delete();
        sticky[0] = 1'b1;
        sticky[2] = 1'b1;
        request(0, 3, 5);
        request(2, 6, 7);
        c = 0;
        while (grant_log.size() < 8 && c < 400) begin
            cycle();
            c++;
        end
        chk("rr_grants_within_budget", 32'(grant_log.size() >= 8), 1);
        sticky[0] = 1'b0;
        sticky[2] = 1'b0;
        run_until_quiet(100);
        for (int k = 0; k < grant_log.size() && k < 8; k++) begin
            chk("rr_expected_id", grant_log[k], (k % 2 == 0) ? 0 : 2);
        end

        // Backpressure: response held for 10 cycles while another requester waits.
        rsp_log.delete();
        rsp_ready = 1'b0;
        request(3, 5, 6);
        c = 0;
        while (!(rsp_valid === 1'b1) && c < 50) begin
            cycle();
            c++;
        end
        chk("bp_rsp_within_budget", 32'(c < 50), 1);
        request(1, 2, 9);
        repeat (10) cycle();
        chk("bp_still_valid", rsp_valid, 1);
        chk("bp_no_rsp_yet", rsp_log.size(), 0);
        rsp_ready = 1'b1;
        run_until_quiet(100);
        chk("bp_rsp_count", rsp_log.size(), 2);
        if (rsp_log.size() == 2) begin
            chk("bp_first_y", rsp_log[0].y, 30);
            chk("bp_second_y", rsp_log[1].y, 18);
        end

        // Reset three cycles after mul_ena, while waiting on the multiplier.
        request(2, 4, 4);
        c = 0;
        while (!(mul_ena === 1'b1) && c < 20) begin
            cycle();
            c++;
        end
        cycle();
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        check_reset_outputs("midwait");
        exp_q.delete();
        pend = '0;
        model_ptr = 0;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rsp_log.delete();
        request(1, 15, 15);
        run_until_quiet(100);
        chk("after_reset_count", rsp_log.size(), 1);
        if (rsp_log.size() == 1) chk("after_reset_y", rsp_log[0].y, 225);

        // Randomized traffic with ready backpressure, two multiplier latencies.
        rand_mode = 1'b1;
        repeat (400) cycle();
        rand_mode = 1'b0;
        rsp_ready = 1'b1;
        run_until_quiet(300);
        mul_lat = 1;
        rand_mode = 1'b1;
        repeat (200) cycle();
        rand_mode = 1'b0;
        rsp_ready = 1'b1;
        run_until_quiet(300);
        mul_lat = 6;

`ifdef MUL_ARB_TIMEOUT_EN
        // Multiplier never completes: watchdog response, then a normal one.
        rsp_log.delete();
        mul_lat = 0;
        request(0, 9, 9);
        run_until_quiet(200);
        mul_lat = 6;
        request(0, 9, 9);
        run_until_quiet(100);
        chk("tmo_count", rsp_log.size(), 2);
        if (rsp_log.size() == 2) begin
            chk("tmo_y", rsp_log[0].y, 255);
            chk("tmo_next_y", rsp_log[1].y, 81);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
